// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: word load/store completing LATENCY wait cycles after acceptance.
// Optional DMEM_MISALIGN_TRAP_EN: misaligned byte addresses fault immediately instead of accessing the word.
module dmem_responder #(
   parameter int DEPTH   = 1024,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_read,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic [31:0] rdata,
   output logic        stall,
   output logic        resp_valid,
   output logic        mem_err
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t      state, state_nxt;
   logic [3:0]  cnt;
   logic        req;
   logic        misalign;
   logic        access;
   logic        mem_we;

   // operation captured in IDLE; inputs are not looked at again until the next IDLE
   logic          lat_write;
   logic          lat_both;
   logic          lat_oob;
   logic [AW-1:0] lat_idx;
   logic [31:0]   lat_wdata;

   logic [31:0] mem [DEPTH];

   logic [31:0] rdata_q;
   logic        resp_valid_q;
   logic        mem_err_q;

   assign req    = req_read | req_write;
   assign access = (state == BUSY) && (cnt == 4'd0);

`ifdef DMEM_MISALIGN_TRAP_EN
   assign misalign = (req_addr[1:0] != 2'b00);
`else
   logic addr_lsb_unused;
   assign addr_lsb_unused = ^req_addr[1:0];
   assign misalign        = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (req) state_nxt = misalign ? DONE : BUSY;
         BUSY:    if (access) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      stall  = 1'b0;
      mem_we = 1'b0;
      if (reset) begin
         case (state)
            IDLE:    stall = req;
            BUSY: begin
               stall  = 1'b1;
               mem_we = access && lat_write && !lat_oob;
            end
            default: stall = 1'b0;
         endcase
      end
   end

   // response registers default to zero so they only carry data in the DONE cycle
   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt          <= 4'd0;
         rdata_q      <= 32'd0;
         resp_valid_q <= 1'b0;
         mem_err_q    <= 1'b0;
         lat_write    <= 1'b0;
         lat_both     <= 1'b0;
         lat_oob      <= 1'b0;
         lat_idx      <= '0;
         lat_wdata    <= 32'd0;
      end else begin
         rdata_q      <= 32'd0;
         resp_valid_q <= 1'b0;
         mem_err_q    <= 1'b0;
         case (state)
            IDLE: begin
               if (req) begin
                  lat_write <= req_write;
                  lat_both  <= req_read & req_write;
                  lat_oob   <= ({2'b00, req_addr[31:2]} >= 32'(DEPTH));
                  lat_idx   <= req_addr[AW+1:2];
                  lat_wdata <= req_wdata;
                  cnt       <= 4'(LATENCY - 1);
                  if (misalign) begin
                     resp_valid_q <= 1'b1;
                     mem_err_q    <= 1'b1;
                  end
               end
            end
            BUSY: begin
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  resp_valid_q <= 1'b1;
                  mem_err_q    <= lat_oob | lat_both;
                  if (!lat_write && !lat_oob) rdata_q <= mem[lat_idx];
               end
            end
            default: ;
         endcase
      end
   end

   // array is deliberately outside the reset domain
   always_ff @(posedge clk) begin
      if (mem_we) mem[lat_idx] <= lat_wdata;
   end

   assign rdata      = rdata_q;
   assign resp_valid = resp_valid_q;
   assign mem_err    = mem_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: randomized loads/stores against a word-array reference model.
module tb_dmem_responder;
   localparam int DEPTH   = 1024;
   localparam int LATENCY = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        req_read = 1'b0;
   logic        req_write = 1'b0;
   logic [31:0] req_addr = 32'd0;
   logic [31:0] req_wdata = 32'd0;
   logic [31:0] rdata;
   logic        stall, resp_valid, mem_err;

   dmem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
      .clk(clk), .reset(reset), .req_read(req_read), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .rdata(rdata),
      .stall(stall), .resp_valid(resp_valid), .mem_err(mem_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          cyc;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   logic [31:0] mdl [DEPTH];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h cyc=%0d", name, got, exp, cyc);
      end
   endtask

   // Reference behaviour: word array, fault rules, response latency in cycles after issue
   task automatic model(input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] r, output bit e, output int lat);
      int unsigned idx;
      bit          oob;
      idx = addr >> 2;
      oob = (idx >= DEPTH);
`ifdef DMEM_MISALIGN_TRAP_EN
      if (addr[1:0] != 2'b00) begin
         r = 32'd0; e = 1'b1; lat = 1;
         return;
      end
`endif
      lat = LATENCY + 1;
      e   = oob || (rd && wr);
      if (wr) begin
         if (!oob) mdl[idx] = wd;
         r = 32'd0;
      end else begin
         r = oob ? 32'd0 : mdl[idx];
      end
   endtask

   task automatic scramble_inputs();
      req_read  = 1'($urandom_range(0, 1));
      req_write = 1'($urandom_range(0, 1));
      req_addr  = $urandom;
      req_wdata = $urandom;
   endtask

   // Entered and left just after a rising edge; scramble=1 drives junk while the op is in flight
   task automatic issue(input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                        input bit scramble);
      logic [31:0] r;
      bit          e;
      int          lat;
      req_read = rd; req_write = wr; req_addr = addr; req_wdata = wd;
      model(rd, wr, addr, wd, r, e, lat);
      sb.push_back('{rdata: r, err: e, cyc: cyc + lat});
      for (int k = 0; k < lat; k++) begin
         @(negedge clk);
         chk("stall_busy", 32'(stall), 32'd1);
         @(posedge clk); #1;
         if (scramble) scramble_inputs();
      end
      @(negedge clk);
      chk("stall_done", 32'(stall), 32'd0);
      @(posedge clk); #1;
      if (scramble) scramble_inputs();
   endtask

   task automatic idle(input int n);
      req_read = 1'b0; req_write = 1'b0;
      repeat (n) begin
         @(negedge clk);
         chk("stall_idle", 32'(stall), 32'd0);
         @(posedge clk); #1;
      end
   endtask

   // Monitor: pops on every response, otherwise requires quiet outputs
   always @(negedge clk) begin
      if (sb.size() > 0 && cyc > sb[0].cyc) begin
         checks++;
         failures++;
         $display("FAIL resp_missing got=none exp_cyc=%0d cyc=%0d", sb[0].cyc, cyc);
         void'(sb.pop_front());
      end
      if (resp_valid === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL resp_unexpected got=resp_valid exp=none cyc=%0d", cyc);
         end else begin
            mon_e = sb.pop_front();
            chk("rdata", rdata, mon_e.rdata);
            chk("mem_err", 32'(mem_err), 32'(mon_e.err));
            chk("resp_cycle", 32'(cyc), 32'(mon_e.cyc));
         end
      end else begin
         chk("rdata_quiet", rdata, 32'd0);
         chk("err_quiet", 32'(mem_err), 32'd0);
         chk("resp_valid_known", 32'(resp_valid), 32'd0);
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog got=timeout exp=finish cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int          kind;
      int unsigned idx;
      bit          rd, wr;
      logic [31:0] addr;

      // reset with a live request: stall must stay low
      @(posedge clk); #1;
      req_read = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("reset_stall", 32'(stall), 32'd0);
         chk("reset_resp", 32'(resp_valid), 32'd0);
         @(posedge clk); #1;
      end
      req_read = 1'b0;
      reset = 1'b1;
      idle(2);

      for (int i = 0; i < 16; i++) issue(1'b0, 1'b1, 32'(i * 4), $urandom, 1'b0);

      // store then load, with the bus scrambled while busy
      issue(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
      issue(1'b1, 1'b0, 32'h10, 32'h0, 1'b1);
      idle(1);

      // index DEPTH faults; the store there must not alias onto word 0
      issue(1'b1, 1'b0, 32'h1000, 32'h0, 1'b0);
      issue(1'b0, 1'b1, 32'h1000, 32'hA5A5A5A5, 1'b0);
      issue(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
      issue(1'b1, 1'b1, 32'h8, 32'h0BADF00D, 1'b0);
      issue(1'b1, 1'b0, 32'h8, 32'h0, 1'b0);

      // reset during the first BUSY cycle aborts the store
      issue(1'b0, 1'b1, 32'h20, 32'h00001234, 1'b0);
      req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h5;
      @(negedge clk);
      chk("abort_stall0", 32'(stall), 32'd1);
      @(posedge clk); #1;
      reset = 1'b0; req_write = 1'b0;
      @(negedge clk);
      chk("abort_stall_rst", 32'(stall), 32'd0);
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      chk("abort_stall_after", 32'(stall), 32'd0);
      chk("abort_resp_after", 32'(resp_valid), 32'd0);
      @(posedge clk); #1;
      issue(1'b1, 1'b0, 32'h20, 32'h0, 1'b0);

      // back-to-back loads held on the inputs through DONE
      issue(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
      issue(1'b1, 1'b0, 32'h4, 32'h0, 1'b0);
      idle(1);

      issue(1'b1, 1'b0, 32'h13, 32'h0, 1'b0);
      issue(1'b0, 1'b1, 32'h16, 32'h77777777, 1'b0);
      issue(1'b1, 1'b0, 32'h14, 32'h0, 1'b0);

      for (int n = 0; n < 200; n++) begin
         kind = int'($urandom_range(0, 9));
         idx  = $urandom_range(0, 15);
         rd   = 1'b1; wr = 1'b0;
         addr = 32'(idx << 2);
         if (kind >= 4 && kind < 7) begin rd = 1'b0; wr = 1'b1; end
         else if (kind == 7) begin wr = 1'b1; end
         else if (kind == 8) begin
            addr = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : 32'($urandom_range(DEPTH, DEPTH + 40) << 2);
            rd = 1'($urandom_range(0, 1));
            wr = ~rd | 1'($urandom_range(0, 1));
         end else if (kind == 9) begin
            addr = addr | 32'($urandom_range(1, 3));
            rd = 1'($urandom_range(0, 1));
            wr = ~rd;
         end
         issue(rd, wr, addr, $urandom, 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
      end

      idle(4);
      chk("sb_drain", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
